// File: rtl/vedic_pkg.sv
// Shared types, constants and small vedic helper functions for the vedic multiplier family.
package vedic_pkg;

    localparam int unsigned OP_W   = 16;
    localparam int unsigned P_W    = 32;
    localparam int unsigned HALF_W = 8;
    localparam int unsigned PP_W   = 16;
    localparam int unsigned STEP_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [STEP_W-1:0] STEP_LL = 2'd0;
    localparam logic [STEP_W-1:0] STEP_HL = 2'd1;
    localparam logic [STEP_W-1:0] STEP_LH = 2'd2;
    localparam logic [STEP_W-1:0] STEP_HH = 2'd3;

    // Left shift applied to each partial product, indexed by step.
    localparam logic [4:0] SHIFT_TAB [4] = '{5'd0, 5'd8, 5'd8, 5'd16};

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operands_t;

    // 2x2 vertical-and-crosswise product.
    function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
        return 4'(x[0] & y[0])
             + 4'({x[1] & y[0], 1'b0})
             + 4'({x[0] & y[1], 1'b0})
             + 4'({x[1] & y[1], 2'b00});
    endfunction

    // 4x4 product built from four 2x2 blocks.
    function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
        return 8'(vm2(x[1:0], y[1:0]))
             + (8'(vm2(x[3:2], y[1:0])) << 2)
             + (8'(vm2(x[1:0], y[3:2])) << 2)
             + (8'(vm2(x[3:2], y[3:2])) << 4);
    endfunction

endpackage

// File: rtl/vedic_8bit.sv
// Combinational 8x8 unsigned vedic multiplier assembled from four 4x4 blocks.
module vedic_8bit
    import vedic_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    output logic [PP_W-1:0]   p
);

    assign p = PP_W'(vm4(a[3:0], b[3:0]))
             + (PP_W'(vm4(a[7:4], b[3:0])) << 4)
             + (PP_W'(vm4(a[3:0], b[7:4])) << 4)
             + (PP_W'(vm4(a[7:4], b[7:4])) << 8);

endmodule

// File: rtl/vedic_16bit_seq.sv
// Sequential 16x16 unsigned multiplier: one shared 8x8 vedic core, four partial
// products accumulated over four cycles, valid/ready on both sides.
module vedic_16bit_seq
    import vedic_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_W-1:0]   p,
    output logic             busy
);

    state_t              state;
    state_t              state_nxt;
    logic [STEP_W-1:0]   step;
    operands_t           opnd;
    logic [P_W-1:0]      acc;
    logic [P_W-1:0]      acc_nxt;
    logic [HALF_W-1:0]   core_a;
    logic [HALF_W-1:0]   core_b;
    logic [PP_W-1:0]     pp16;
    logic                accept;

    // State register; out_valid and busy are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = MUL;
            MUL:  if (step == STEP_HH) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = accept ? MUL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; in_ready depends combinationally on out_ready in DONE.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            in_ready = (state == IDLE) || ((state == DONE) && out_ready);
        end
        accept = in_valid && in_ready;
    end

    // Operand-half select for the shared core.
    always_comb begin
        core_a = opnd.a[HALF_W-1:0];
        core_b = opnd.b[HALF_W-1:0];
        case (step)
            STEP_LL: ;
            STEP_HL: core_a = opnd.a[OP_W-1:HALF_W];
            STEP_LH: core_b = opnd.b[OP_W-1:HALF_W];
            STEP_HH: begin
                core_a = opnd.a[OP_W-1:HALF_W];
                core_b = opnd.b[OP_W-1:HALF_W];
            end
            default: ;
        endcase
    end

    vedic_8bit u_core (
        .a (core_a),
        .b (core_b),
        .p (pp16)
    );

    assign acc_nxt = acc + (P_W'(pp16) << SHIFT_TAB[step]);

    // Operand capture, accumulation and product register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opnd <= '0;
            acc  <= '0;
            step <= '0;
            p    <= '0;
        end else if (accept) begin
            opnd <= '{a: a, b: b};
            acc  <= '0;
            step <= STEP_LL;
        end else if (state == MUL) begin
            acc  <= acc_nxt;
            step <= step + STEP_W'(1);
            if (step == STEP_HH) begin
                p <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vedic_16bit_seq.sv
// Directed and random checks of the sequential 16x16 vedic multiplier.
module tb_vedic_16bit_seq;
    import vedic_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    logic [32:0] mon_sum;
    logic [4:0]  mon_sh;

    always #5 clk = ~clk;

    vedic_16bit_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Count output transfers.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) xfers++;
    end

    // Accumulator must never carry out of bit 31.
    always @(negedge clk) begin
        if (rst_n && dut.state == MUL) begin
            mon_sh  = (dut.step == 2'd0) ? 5'd0 : (dut.step == 2'd3) ? 5'd16 : 5'd8;
            mon_sum = {1'b0, dut.acc} + ({17'b0, dut.pp16} << mon_sh);
            chk("acc_carry", 32'(mon_sum[32]), 32'd0);
        end
    end

    task automatic issue(input logic [15:0] aa, input logic [15:0] bb);
        in_valid = 1'b1;
        a = aa;
        b = bb;
        #1;
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        a = ~aa;
        b = ~bb;
    endtask

    task automatic expect_result(input logic [31:0] exp);
        repeat (4) begin
            @(negedge clk);
            chk("mul_out_valid", 32'(out_valid), 32'd0);
            chk("mul_busy", 32'(busy), 32'd1);
            chk("mul_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_p", p, exp);
        chk("done_busy", 32'(busy), 32'd1);
    endtask

    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] cur_exp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_p", p, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        issue(16'h1234, 16'h5678);
        expect_result(32'h0626_0060);
        release_out();

        issue(16'hFFFF, 16'hFFFF);
        expect_result(32'hFFFE_0001);
        release_out();

        issue(16'h0000, 16'hBEEF);
        expect_result(32'h0000_0000);
        release_out();
        issue(16'h0001, 16'hABCD);
        expect_result(32'h0000_ABCD);
        release_out();

        // Backpressure, then back-to-back accept in DONE.
        issue(16'h00C8, 16'h0011);
        expect_result(32'h0000_0D48);
        in_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_p", p, 32'h0000_0D48);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        chk("bp_xfers", 32'(xfers), 32'd4);
        out_ready = 1'b1;
        issue(16'h0003, 16'h0005);
        out_ready = 1'b0;
        chk("b2b_xfers", 32'(xfers), 32'd5);
        expect_result(32'h0000_000F);
        release_out();

        // Reset during MUL at step 2.
        issue(16'hAAAA, 16'h5555);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_step", 32'(dut.step), 32'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_pulse", 32'(out_valid), 32'd0);
        end
        issue(16'h00FF, 16'h0100);
        expect_result(32'h0000_FF00);
        release_out();
        chk("directed_xfers", 32'(xfers), 32'd7);

        // Random back-to-back stream, one product every five cycles.
        out_ready = 1'b1;
        ra = 16'($urandom_range(0, 65535));
        rb = 16'($urandom_range(0, 65535));
        cur_exp = 32'(ra) * 32'(rb);
        issue(ra, rb);
        for (int i = 0; i < 1000; i++) begin
            expect_result(cur_exp);
            if (i < 999) begin
                ra = 16'($urandom_range(0, 65535));
                rb = 16'($urandom_range(0, 65535));
                cur_exp = 32'(ra) * 32'(rb);
                issue(ra, rb);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("end_out_valid", 32'(out_valid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("total_xfers", 32'(xfers), 32'd1007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
